// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch stage between imem (req/ack) and decode (valid/ready).
// Optional feature: define FETCH_HALT_EN to stop fetching after an accepted ECALL.
//
// state | meaning
// ------+------------------------------------------------------------
// REQ   | launch a request for pc next cycle
// WAIT  | request outstanding, waiting for imem_ack
// HOLD  | instruction presented to decode, waiting for ins_ready
// DRAIN | stale request outstanding after redirect; discard its ack
// HALT  | ECALL accepted, fetch stopped until redirect
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ins_pc_q, ins_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] redirect_target;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] ECALL = 32'h0000_0073;
    logic halted_q, halted_d;
`endif

    assign redirect_target = redirect_pc & ~32'd3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        req_addr_d = req_addr_q;
        ins_d      = ins_q;
        ins_pc_d   = ins_pc_q;
        valid_d    = valid_q;
`ifdef FETCH_HALT_EN
        halted_d   = halted_q;
`endif
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else begin
                    req_d      = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    req_d    = 1'b0;
                    ins_d    = imem_rdata;
                    ins_pc_d = req_addr_q;
                    valid_d  = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (ins_ready) begin
                    valid_d = 1'b0;
`ifdef FETCH_HALT_EN
                    if (ins_q == ECALL) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_REQ;
                    end
`else
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
`endif
                end
            end
            S_DRAIN: begin
                // An ack coinciding with a further redirect still retires the stale request.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
`ifdef FETCH_HALT_EN
                if (redirect_valid) begin
                    halted_d = 1'b0;
                    pc_d     = redirect_target;
                    state_d  = S_REQ;
                end
`else
                state_d = S_REQ;
`endif
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            req_addr_q <= RESET_PC;
            ins_q      <= 32'd0;
            ins_pc_q   <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            ins_q      <= ins_d;
            ins_pc_q   <= ins_pc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign imem_req  = req_q;
    assign imem_addr = req_addr_q;
    assign ins_valid = valid_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a transaction-level model
// (expected instruction stream, outstanding-request tracking, stale-ack discard).
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    inst_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    // model state
    logic [31:0] exp_pc;
    bit          exp_valid;
    logic [31:0] exp_ins;
    logic [31:0] exp_ins_pc;
    bit          halted_exp;
    bit          outstanding;
    bit          stale;
    logic [31:0] req_addr;
    int          lat_cnt;

    // memory behaviour knobs
    int          mem_lat = 0;
    bit          spur_en = 1'b0;
    bit          spur_force = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    bit          ecall_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (ecall_en && a == 32'h10) return 32'h0000_0073;
        return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1000_0000;
    endfunction

    // One clock: check outputs against the model at the negedge, drive inputs, advance the model.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
        bit          ack;
        logic [31:0] rd;
        chkb("halted", halted, halted_exp);
        chkb("ins_valid", ins_valid, exp_valid);
        if (exp_valid) begin
            chk("ins", ins, exp_ins);
            chk("ins_pc", ins_pc, exp_ins_pc);
        end
        if (outstanding) begin
            chkb("req_held", imem_req, 1'b1);
            chk("addr_stable", imem_addr, req_addr);
        end else begin
            if (exp_valid || halted_exp) chkb("no_req", imem_req, 1'b0);
            if (imem_req) begin
                chk("req_addr", imem_addr, exp_pc);
                outstanding = 1'b1;
                stale       = 1'b0;
                req_addr    = imem_addr;
                lat_cnt     = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
        end

        ack = 1'b0;
        rd  = $urandom;
        if (outstanding) begin
            if (lat_cnt == 0) begin
                ack = 1'b1;
                if (ovr_en) begin
                    rd     = ovr_data;
                    ovr_en = 1'b0;
                end else begin
                    rd = mem_data(req_addr);
                end
            end else begin
                lat_cnt--;
            end
        end else if (spur_force || (spur_en && $urandom_range(0, 5) == 0)) begin
            ack = 1'b1;
        end
        imem_ack       = ack;
        imem_rdata     = rd;
        ins_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;

        if (redir) begin
            exp_pc     = tgt & ~32'd3;
            exp_valid  = 1'b0;
            halted_exp = 1'b0;
            if (outstanding) stale = 1'b1;
        end else if (exp_valid && rdy) begin
            n_acc++;
            exp_valid = 1'b0;
            if (HALT_EN && exp_ins == 32'h0000_0073) halted_exp = 1'b1;
            else exp_pc = exp_pc + 32'd4;
        end
        if (outstanding && ack) begin
            outstanding = 1'b0;
            if (!redir && !stale) begin
                exp_valid  = 1'b1;
                exp_ins    = rd;
                exp_ins_pc = req_addr;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; ins_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", ins_valid, 1'b0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_ins_pc", ins_pc, 32'h0);
        chkb("rst_halted", halted, 1'b0);
        outstanding = 1'b0; stale = 1'b0; exp_valid = 1'b0;
        exp_pc = RESET_PC; halted_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_req(input bit rdy);
        int n = 0;
        while (!(imem_req && !outstanding) && n < 40) begin
            cycle(rdy, 1'b0, 32'h0);
            n++;
        end
        chkb("req_timeout", imem_req && !outstanding, 1'b1);
    endtask

    task automatic wait_valid_at(input logic [31:0] a);
        int n = 0;
        while (!(ins_valid && ins_pc == a) && n < 60) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        chkb("valid_timeout", ins_valid && ins_pc == a, 1'b1);
    endtask

    initial begin
        rst_n = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; ins_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        do_reset();

        // first fetch from RESET_PC with zero-wait memory
        mem_lat = 0;
        cycle(1'b1, 1'b0, 32'h0);
        chkb("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, RESET_PC);
        cycle(1'b1, 1'b0, 32'h0);
        chkb("first_valid", ins_valid, 1'b1);
        chk("first_ins", ins, 32'h0050_0093);
        chk("first_ins_pc", ins_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        run_until_req(1'b1);
        chk("second_addr", imem_addr, 32'h4);

        // slow memory then decode stall
        mem_lat = 3;
        for (int i = 0; i < 4; i++) begin
            chkb("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, 32'h4);
            cycle(1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            chkb("stall_valid", ins_valid, 1'b1);
            chk("stall_pc", ins_pc, 32'h4);
            chk("stall_ins", ins, mem_data(32'h4));
            chkb("stall_no_req", imem_req, 1'b0);
            cycle(1'b0, 1'b0, 32'h0);
        end
        mem_lat = 0;
        cycle(1'b1, 1'b0, 32'h0);

        // redirect to 0x40 in HOLD at pc 0x8 while ready is high
        wait_valid_at(32'h8);
        cycle(1'b1, 1'b1, 32'h40);
        chkb("hold_redir_drop", ins_valid, 1'b0);
        run_until_req(1'b1);
        chk("hold_redir_addr", imem_addr, 32'h40);

        // redirect to 0x103 during WAIT; stale ack carries DEADBEEF
        mem_lat  = 2;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        cycle(1'b0, 1'b1, 32'h103);
        mem_lat = 0;
        run_until_req(1'b1);
        chk("drain_redir_addr", imem_addr, 32'h100);

        // reset mid-fetch, then a late ack
        mem_lat = 3;
        cycle(1'b0, 1'b0, 32'h0);
        do_reset();
        spur_force = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        spur_force = 1'b0;
        mem_lat = 0;
        chkb("late_ack_valid", ins_valid, 1'b0);
        chk("restart_addr", imem_addr, RESET_PC);
        wait_valid_at(RESET_PC);

        // ECALL at 0x10
        ecall_en = 1'b1;
        cycle(1'b0, 1'b1, 32'h10);
        wait_valid_at(32'h10);
        chk("ecall_ins", ins, 32'h0000_0073);
        cycle(1'b1, 1'b0, 32'h0);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 4; i++) begin
            chkb("halt_flag", halted, 1'b1);
            chkb("halt_no_req", imem_req, 1'b0);
            cycle(1'b1, 1'b0, 32'h0);
        end
        cycle(1'b0, 1'b1, 32'h20);
        run_until_req(1'b1);
        chk("halt_redir_addr", imem_addr, 32'h20);
        chkb("halt_cleared", halted, 1'b0);
`else
        run_until_req(1'b1);
        chk("ecall_next_addr", imem_addr, 32'h14);
        chkb("never_halted", halted, 1'b0);
`endif
        ecall_en = 1'b0;

        // pc wrap at the top of the address space
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
        wait_valid_at(32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0);
        run_until_req(1'b1);
        chk("wrap_addr", imem_addr, 32'h0);

        // sustained throughput with zero-wait memory
        n_acc = 0;
        repeat (30) cycle(1'b1, 1'b0, 32'h0);
        chkb("throughput", n_acc >= 9, 1'b1);

        // randomized traffic
        mem_lat = -1;
        spur_en = 1'b1;
        repeat (3000) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
        end
        spur_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
